// File: rtl/vector_alu_seq.sv
// Sequential vector ALU: processes one register of a LMUL group per RUN cycle and
// writes its result one cycle later, applying mask/tail agnostic fill policies.
module vector_alu_seq #(
    parameter  int VLEN  = 64,
    localparam int VLENB = VLEN / 8,
    localparam int VLW   = $clog2(VLEN) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [2:0]       op_i,
    input  logic [1:0]       src_sel_i,
    input  logic [4:0]       vs1_i,
    input  logic [4:0]       vs2_i,
    input  logic [4:0]       vd_i,
    input  logic [31:0]      scalar_i,
    input  logic [4:0]       imm_i,
    input  logic             vm_i,
    input  logic             vta_i,
    input  logic             vma_i,
    input  logic [1:0]       vsew_i,
    input  logic [1:0]       vlmul_i,
    input  logic [VLW-1:0]   vl_i,
    output logic [4:0]       rf_raddr_a_o,
    output logic [4:0]       rf_raddr_b_o,
    output logic [4:0]       rf_raddr_c_o,
    input  logic [VLEN-1:0]  rf_rdata_a_i,
    input  logic [VLEN-1:0]  rf_rdata_b_i,
    input  logic [VLEN-1:0]  rf_rdata_c_i,
    input  logic [VLEN-1:0]  v0_i,
    output logic             rf_we_o,
    output logic [4:0]       rf_waddr_o,
    output logic [VLEN-1:0]  rf_wdata_o,
    output logic [VLENB-1:0] rf_wbe_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);
    localparam int AW = $clog2(VLEN);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    typedef struct packed {
        logic [2:0]     op;
        logic [1:0]     src;
        logic [4:0]     vs1, vs2, vd;
        logic [31:0]    scalar;
        logic [4:0]     imm;
        logic           vm, vta, vma;
        logic [1:0]     sew, lmul;
        logic [VLW-1:0] vl;
        logic           err;
    } issue_t;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    issue_t           iss_q, iss_d;
    logic             we_q, we_d;
    logic [4:0]       waddr_q, waddr_d;
    logic [VLEN-1:0]  wdata_q, wdata_d;
    logic [VLENB-1:0] wbe_q, wbe_d;

    // {write enable, write all-ones} for global element e
    function automatic logic [1:0] policy(input int e, input int vle, input issue_t s, input logic v0b);
        if (e < vle) begin
            if (s.vm || v0b) return 2'b10;
            return s.vma ? 2'b11 : 2'b00;
        end
        return s.vta ? 2'b11 : 2'b00;
    endfunction

    function automatic logic [31:0] lane(input issue_t s, input logic [31:0] a, input logic [31:0] vv,
                                         input logic [31:0] m, input logic [1:0] pol);
        logic [31:0] b;
        logic [31:0] r;
        case (s.src)
            2'd1:    b = s.scalar;
            2'd2:    b = {{27{s.imm[4]}}, s.imm};
            default: b = vv;
        endcase
        b = b & m;
        case (s.op)
            3'd0:    r = a + b;
            3'd1:    r = a - b;
            3'd2:    r = a & b;
            3'd3:    r = a | b;
            3'd4:    r = a ^ b;
            3'd5:    r = (a < b) ? a : b;
            3'd6:    r = (a > b) ? a : b;
            default: r = '0;
        endcase
        return pol[0] ? m : (r & m);
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        iss_d   = iss_q;
        case (state_q)
            IDLE: if (start_i) begin
                state_d      = RUN;
                idx_d        = '0;
                iss_d.op     = op_i;
                iss_d.src    = src_sel_i;
                iss_d.vs1    = vs1_i;
                iss_d.vs2    = vs2_i;
                iss_d.vd     = vd_i;
                iss_d.scalar = scalar_i;
                iss_d.imm    = imm_i;
                iss_d.vm     = vm_i;
                iss_d.vta    = vta_i;
                iss_d.vma    = vma_i;
                iss_d.sew    = vsew_i;
                iss_d.lmul   = vlmul_i;
                iss_d.vl     = vl_i;
                iss_d.err    = (vsew_i == 2'd3) || (op_i == 3'd7) || (src_sel_i == 2'd3) ||
                               (!vm_i && vd_i == 5'd0);
            end
            // ~(111 << lmul) is N-1 for N = 2^lmul
            RUN: if (idx_q == ~(3'b111 << iss_q.lmul)) state_d = DRAIN;
                 else idx_d = idx_q + 3'd1;
            DRAIN: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        int          epr, vlmax, vle, e;
        logic [1:0]  pol;
        logic [31:0] res;
        wdata_d = '0;
        wbe_d   = '0;
        pol     = '0;
        res     = '0;
        e       = 0;
        epr     = VLENB >> iss_q.sew;
        vlmax   = epr << iss_q.lmul;
        vle     = (int'(iss_q.vl) < vlmax) ? int'(iss_q.vl) : vlmax;
        // disabled bytes carry the old vd contents so a full-width write stays undisturbed
        case (iss_q.sew)
            2'd0: for (int j = 0; j < VLENB; j++) begin
                e   = int'(idx_q) * epr + j;
                pol = policy(e, vle, iss_q, v0_i[e[AW-1:0]]);
                res = lane(iss_q, 32'(rf_rdata_a_i[8*j +: 8]), 32'(rf_rdata_b_i[8*j +: 8]), 32'hFF, pol);
                wdata_d[8*j +: 8] = pol[1] ? res[7:0] : rf_rdata_c_i[8*j +: 8];
                wbe_d[j]          = pol[1];
            end
            2'd1: for (int j = 0; j < VLENB / 2; j++) begin
                e   = int'(idx_q) * epr + j;
                pol = policy(e, vle, iss_q, v0_i[e[AW-1:0]]);
                res = lane(iss_q, 32'(rf_rdata_a_i[16*j +: 16]), 32'(rf_rdata_b_i[16*j +: 16]), 32'hFFFF, pol);
                wdata_d[16*j +: 16] = pol[1] ? res[15:0] : rf_rdata_c_i[16*j +: 16];
                wbe_d[2*j +: 2]     = {2{pol[1]}};
            end
            2'd2: for (int j = 0; j < VLENB / 4; j++) begin
                e   = int'(idx_q) * epr + j;
                pol = policy(e, vle, iss_q, v0_i[e[AW-1:0]]);
                res = lane(iss_q, rf_rdata_a_i[32*j +: 32], rf_rdata_b_i[32*j +: 32], 32'hFFFF_FFFF, pol);
                wdata_d[32*j +: 32] = pol[1] ? res : rf_rdata_c_i[32*j +: 32];
                wbe_d[4*j +: 4]     = {4{pol[1]}};
            end
            default: ;
        endcase
        if (state_q != RUN || iss_q.err) begin
            wdata_d = '0;
            wbe_d   = '0;
        end
        we_d    = |wbe_d;
        waddr_d = (state_q == RUN) ? iss_q.vd + {2'b00, idx_q} : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            iss_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            wbe_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            iss_q   <= iss_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wbe_q   <= wbe_d;
        end
    end

    assign rf_raddr_a_o = (state_q == RUN) ? iss_q.vs2 + {2'b00, idx_q} : '0;
    assign rf_raddr_b_o = (state_q == RUN) ? iss_q.vs1 + {2'b00, idx_q} : '0;
    assign rf_raddr_c_o = (state_q == RUN) ? iss_q.vd  + {2'b00, idx_q} : '0;
    assign rf_we_o      = we_q;
    assign rf_waddr_o   = waddr_q;
    assign rf_wdata_o   = wdata_q;
    assign rf_wbe_o     = wbe_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = (state_q == DRAIN);
    assign error_o      = (state_q == DRAIN) && iss_q.err;

endmodule

// File: tb/tb_vector_alu_seq.sv
// Bench for vector_alu_seq: element-level reference model, per-cycle compare process,
// directed corner cases plus randomized issues.
module tb_vector_alu_seq;
    localparam int VLEN = 64;
    localparam int VLENB = 8;
    localparam int VLW = 7;

    logic clk = 1'b0, reset_n = 1'b0, start_i = 1'b0;
    logic [2:0] op_i;
    logic [1:0] src_sel_i, vsew_i, vlmul_i;
    logic [4:0] vs1_i, vs2_i, vd_i, imm_i;
    logic [31:0] scalar_i;
    logic vm_i, vta_i, vma_i;
    logic [VLW-1:0] vl_i;
    logic [4:0] rf_raddr_a_o, rf_raddr_b_o, rf_raddr_c_o, rf_waddr_o;
    logic [VLEN-1:0] rf_rdata_a_i, rf_rdata_b_i, rf_rdata_c_i, v0_i, rf_wdata_o;
    logic [VLENB-1:0] rf_wbe_o;
    logic rf_we_o, busy_o, done_o, error_o;

    logic [VLEN-1:0] rf [32];
    assign rf_rdata_a_i = rf[rf_raddr_a_o];
    assign rf_rdata_b_i = rf[rf_raddr_b_o];
    assign rf_rdata_c_i = rf[rf_raddr_c_o];

    vector_alu_seq #(.VLEN(VLEN)) dut (
        .clk(clk), .reset_n(reset_n), .start_i(start_i), .op_i(op_i), .src_sel_i(src_sel_i),
        .vs1_i(vs1_i), .vs2_i(vs2_i), .vd_i(vd_i), .scalar_i(scalar_i), .imm_i(imm_i),
        .vm_i(vm_i), .vta_i(vta_i), .vma_i(vma_i), .vsew_i(vsew_i), .vlmul_i(vlmul_i), .vl_i(vl_i),
        .rf_raddr_a_o(rf_raddr_a_o), .rf_raddr_b_o(rf_raddr_b_o), .rf_raddr_c_o(rf_raddr_c_o),
        .rf_rdata_a_i(rf_rdata_a_i), .rf_rdata_b_i(rf_rdata_b_i), .rf_rdata_c_i(rf_rdata_c_i),
        .v0_i(v0_i), .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .rf_wbe_o(rf_wbe_o), .busy_o(busy_o), .done_o(done_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int model_t = 0;
    int m_n = 1;
    bit m_err = 1'b0;
    logic [4:0] m_vs1, m_vs2, m_vd;
    logic [63:0] exp_data [8];
    logic [7:0]  exp_be [8];
    logic [4:0]  exp_addr [8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic logic [63:0] bytemask(input logic [7:0] be);
        logic [63:0] m = '0;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    // Expected register writes computed element by element from the issue fields
    task automatic build_model();
        int sewb, epr, vlmax, vle, ri, j;
        logic [63:0] mk, a, b, res, val;
        bit en;
        m_n = 1 << vlmul_i;
        m_vs1 = vs1_i; m_vs2 = vs2_i; m_vd = vd_i;
        m_err = (vsew_i == 3) || (op_i == 7) || (src_sel_i == 3) || (!vm_i && vd_i == 0);
        for (int r = 0; r < 8; r++) begin
            exp_data[r] = '0; exp_be[r] = '0; exp_addr[r] = 5'(vd_i + r);
        end
        if (m_err) return;
        sewb = 8 << vsew_i;
        epr = VLENB >> vsew_i;
        vlmax = epr * m_n;
        vle = (int'(vl_i) < vlmax) ? int'(vl_i) : vlmax;
        mk = (64'd1 << sewb) - 64'd1;
        for (int g = 0; g < vlmax; g++) begin
            ri = g / epr;
            j = g % epr;
            a = (rf[5'(vs2_i + ri)] >> (j * sewb)) & mk;
            case (src_sel_i)
                0: b = (rf[5'(vs1_i + ri)] >> (j * sewb)) & mk;
                1: b = {32'b0, scalar_i} & mk;
                default: b = {{59{imm_i[4]}}, imm_i} & mk;
            endcase
            case (op_i)
                0: res = a + b;
                1: res = a - b;
                2: res = a & b;
                3: res = a | b;
                4: res = a ^ b;
                5: res = (a < b) ? a : b;
                default: res = (a > b) ? a : b;
            endcase
            res &= mk;
            if (g < vle) begin
                en = vm_i || v0_i[g];
                val = en ? res : mk;
                en = en || vma_i;
            end else begin
                en = vta_i;
                val = mk;
            end
            if (en) begin
                exp_data[ri] |= val << (j * sewb);
                exp_be[ri] |= 8'(((1 << (sewb / 8)) - 1) << (j * sewb / 8));
            end
        end
    endtask

    // Model timeline: t = 1..N are RUN cycles, N+1 is DRAIN, 0 is idle
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_t <= 0;
        else if (model_t == 0) model_t <= start_i ? 1 : 0;
        else if (model_t >= m_n + 1) model_t <= 0;
        else model_t <= model_t + 1;
    end

    always @(negedge clk) begin
        int t;
        bit ewe;
        t = model_t;
        if (!reset_n) begin
            chk("rst_busy", 64'(busy_o), 0);
            chk("rst_done", 64'(done_o), 0);
            chk("rst_error", 64'(error_o), 0);
            chk("rst_we", 64'(rf_we_o), 0);
            chk("rst_wbe", 64'(rf_wbe_o), 0);
            chk("rst_wdata", rf_wdata_o, 0);
            chk("rst_raddr_a", 64'(rf_raddr_a_o), 0);
        end else begin
            ewe = (t >= 2) && (t <= m_n + 1) && !m_err && (exp_be[(t >= 2) ? t - 2 : 0] != 0);
            chk("busy", 64'(busy_o), 64'(t >= 1));
            chk("done", 64'(done_o), 64'(t == m_n + 1));
            chk("error", 64'(error_o), 64'(t == m_n + 1 && m_err));
            chk("we", 64'(rf_we_o), 64'(ewe));
            if (ewe && rf_we_o) begin
                chk("waddr", 64'(rf_waddr_o), 64'(exp_addr[t-2]));
                chk("wbe", 64'(rf_wbe_o), 64'(exp_be[t-2]));
                chk("wdata", rf_wdata_o & bytemask(exp_be[t-2]), exp_data[t-2]);
            end
            if (t >= 1 && t <= m_n) begin
                chk("raddr_a", 64'(rf_raddr_a_o), 64'(5'(m_vs2 + t - 1)));
                chk("raddr_b", 64'(rf_raddr_b_o), 64'(5'(m_vs1 + t - 1)));
                chk("raddr_c", 64'(rf_raddr_c_o), 64'(5'(m_vd + t - 1)));
            end
        end
    end

    task automatic set_defaults();
        for (int r = 0; r < 32; r++) rf[r] = {$urandom, $urandom};
        op_i = 0; src_sel_i = 0; vs1_i = 1; vs2_i = 2; vd_i = 3; scalar_i = 0; imm_i = 0;
        vm_i = 1; vta_i = 0; vma_i = 0; vsew_i = 0; vlmul_i = 0; vl_i = 8; v0_i = '0;
    endtask

    task automatic issue();
        build_model();
        start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        chk("accept_busy", 64'(busy_o), 1);
    endtask

    task automatic wait_idle();
        int k = 0;
        while (model_t != 0 && k < 30) begin
            @(posedge clk); #1;
            k++;
        end
        if (model_t != 0) begin
            errors++;
            $display("FAIL idle_timeout: got t=%0d required 0", model_t);
        end
    endtask

    initial begin
        set_defaults();
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        @(posedge clk); #1;

        // e32 LMUL1 vl=2 VV add
        set_defaults();
        vsew_i = 2; vl_i = 2; vs2_i = 2; vs1_i = 3; vd_i = 4;
        rf[2] = 64'h00000005_FFFFFFFF; rf[3] = 64'h00000001_00000001;
        issue();
        chk("pin_e32_data", exp_data[0], 64'h00000006_00000000);
        chk("pin_e32_be", 64'(exp_be[0]), 64'hFF);
        wait_idle();

        // e8 LMUL2 vl=12 VX add, tail undisturbed
        set_defaults();
        vlmul_i = 1; vl_i = 12; src_sel_i = 1; scalar_i = 32'h1;
        issue();
        chk("pin_tail_be0", 64'(exp_be[0]), 64'hFF);
        chk("pin_tail_be1", 64'(exp_be[1]), 64'h0F);
        wait_idle();

        // e16 masked with vma=1
        set_defaults();
        vsew_i = 1; vl_i = 4; vm_i = 0; v0_i = 64'h5; vma_i = 1; vd_i = 1;
        issue();
        chk("pin_mask_ones", exp_data[0] & 64'hFFFF0000_FFFF0000, 64'hFFFF0000_FFFF0000);
        chk("pin_mask_be", 64'(exp_be[0]), 64'hFF);
        wait_idle();

        // e8 minu VI imm=-1, vd wraps 31 -> 0
        set_defaults();
        op_i = 5; src_sel_i = 2; imm_i = 5'h1F; vs2_i = 4; vd_i = 31; vlmul_i = 1; vl_i = 16;
        rf[4] = 64'h07060504_03020100;
        issue();
        chk("pin_minu_data", exp_data[0], 64'h07060504_03020100);
        chk("pin_wrap_addr", 64'(exp_addr[1]), 0);
        wait_idle();

        // vm=0 with vd=0 is an error; a start while busy is ignored
        set_defaults();
        vm_i = 0; vd_i = 0; vlmul_i = 1;
        issue();
        chk("pin_err", 64'(m_err), 1);
        start_i = 1'b1; op_i = 0; vm_i = 1; vd_i = 5;
        @(posedge clk); #1;
        start_i = 1'b0;
        wait_idle();
        repeat (2) @(posedge clk);
        #1;

        // vl=0 with tail undisturbed: no writes, normal length
        set_defaults();
        vl_i = 0; vlmul_i = 1;
        issue();
        chk("pin_vl0_be", 64'(exp_be[0] | exp_be[1]), 0);
        wait_idle();

        // reset during RUN idx=1 of an LMUL4 group
        set_defaults();
        vlmul_i = 2; vl_i = 32;
        issue();
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy_o), 0);
        chk("midrst_we", 64'(rf_we_o), 0);
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;

        for (int n = 0; n < 40; n++) begin
            for (int r = 0; r < 32; r++) rf[r] = {$urandom, $urandom};
            op_i = 3'($urandom_range(0, 6));
            if ($urandom_range(0, 15) == 0) op_i = 7;
            src_sel_i = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) src_sel_i = 3;
            vsew_i = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 15) == 0) vsew_i = 3;
            vlmul_i = 2'($urandom_range(0, 3));
            vl_i = 7'($urandom_range(0, 72));
            vs1_i = 5'($urandom); vs2_i = 5'($urandom); vd_i = 5'($urandom);
            scalar_i = $urandom; imm_i = 5'($urandom);
            vm_i = 1'($urandom); vta_i = 1'($urandom); vma_i = 1'($urandom);
            v0_i = {$urandom, $urandom};
            issue();
            wait_idle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
